pong_core: RTL and testbench

PONG_CORE -- requirements
Module: pong_core

---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_paddle.sv | 47 ++++
 rtl/pong_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_pong_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types for the pong game core: FSM states, paddle direction and win codes.
// Build option: define PONG_AI_PLAYER2_EN to let the core steer paddle 2 itself.
// Pure declarations, no logic.
package pong_pkg;

   // Game FSM states; the encoding is visible on the state output.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_POINT    = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_e;

   // Paddle direction request as carried on p*_dy: {down, up}, active-high.
   typedef struct packed {
      logic down;
      logic up;
   } dir_t;

   // Encoding of the win output.
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_paddle.sv
// Paddle position register: steps one row up or down per enabled cycle.
// Latency: position updates on the clock edge where en_i is high.
// The position saturates at 0 and MAX_POS; conflicting or idle requests hold it.
module pong_paddle
   import pong_pkg::*;
#(
   parameter int BIT_WIDTH = 10,
   parameter int MAX_POS   = 21,
   parameter int RESET_POS = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  dir_t                 dir_i,
   output logic [BIT_WIDTH-1:0] pos_o
);

   localparam logic [BIT_WIDTH-1:0] MAX_POS_C = BIT_WIDTH'(MAX_POS);
   localparam logic [BIT_WIDTH-1:0] RST_POS_C = BIT_WIDTH'(RESET_POS);

   logic [BIT_WIDTH-1:0] pos_q;
   logic [BIT_WIDTH-1:0] pos_d;

   // Next position: single-direction request only, saturating at both ends.
   always_comb begin
      pos_d = pos_q;
      if (en_i) begin
         if (dir_i.up && !dir_i.down && (pos_q != '0)) begin
            pos_d = pos_q - 1'b1;
         end else if (dir_i.down && !dir_i.up && (pos_q < MAX_POS_C)) begin
            pos_d = pos_q + 1'b1;
         end
      end
   end

   // Position register with asynchronous reset to the centred row.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pos_q <= RST_POS_C;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/pong_core.sv
// Pong game core: serve/play/score FSM, ball motion with wall and paddle bounces.
// Latency: every game step lands one cycle after the tick that caused it.
// pause freezes everything; start is taken on any cycle in IDLE or GAMEOVER.
// Build option PONG_AI_PLAYER2_EN: paddle 2 tracks the ball and p2_dy is ignored.
module pong_core
   import pong_pkg::*;
#(
   parameter int BIT_WIDTH     = 10,
   parameter int MAX_X         = 31,
   parameter int MAX_Y         = 23,
   parameter int PADDLE_LENGTH = 3,
   parameter int EDGE_OFFSET   = 3,
   parameter int SERVE_DELAY   = 4,
   parameter int SCORE_LIMIT   = 3,
   localparam int SCORE_W      = $clog2(SCORE_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 start,
   input  logic                 pause,
   input  logic [1:0]           p1_dy,
   input  logic [1:0]           p2_dy,
   output logic [BIT_WIDTH-1:0] ball_x,
   output logic [BIT_WIDTH-1:0] ball_y,
   output logic [BIT_WIDTH-1:0] p1_y,
   output logic [BIT_WIDTH-1:0] p2_y,
   output logic [SCORE_W-1:0]   score1,
   output logic [SCORE_W-1:0]   score2,
   output logic [1:0]           win,
   output logic [2:0]           state,
   output logic                 point
);

   localparam int CNT_W   = $clog2(SERVE_DELAY + 1);
   localparam int PAD_MAX = MAX_Y - PADDLE_LENGTH + 1;
   localparam int PAD_RST = (MAX_Y + 1 - PADDLE_LENGTH) / 2;

   localparam logic [BIT_WIDTH-1:0] MAX_X_C   = BIT_WIDTH'(MAX_X);
   localparam logic [BIT_WIDTH-1:0] MAX_Y_C   = BIT_WIDTH'(MAX_Y);
   localparam logic [BIT_WIDTH-1:0] CENTER_X  = BIT_WIDTH'(MAX_X / 2);
   localparam logic [BIT_WIDTH-1:0] CENTER_Y  = BIT_WIDTH'(MAX_Y / 2);
   localparam logic [BIT_WIDTH-1:0] P1_HIT_X  = BIT_WIDTH'(EDGE_OFFSET + 1);
   localparam logic [BIT_WIDTH-1:0] P2_HIT_X  = BIT_WIDTH'(MAX_X - EDGE_OFFSET - 1);
   localparam logic [BIT_WIDTH:0]   PAD_SPAN  = (BIT_WIDTH + 1)'(PADDLE_LENGTH - 1);
   localparam logic [CNT_W-1:0]     SERVE_END = CNT_W'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0]   SCORE_LIM = SCORE_W'(SCORE_LIMIT);

   state_e               state_q;
   logic [BIT_WIDTH-1:0] ball_x_q;
   logic [BIT_WIDTH-1:0] ball_y_q;
   logic                 ball_left_q;
   logic                 ball_up_q;
   logic                 serve_right_q;
   logic [CNT_W-1:0]     serve_cnt_q;
   logic [SCORE_W-1:0]   score1_q;
   logic [SCORE_W-1:0]   score2_q;
   logic [1:0]           win_q;
   logic                 point_q;

   logic                 adv;
   logic                 paddle_en;
   logic [BIT_WIDTH-1:0] p1_y_w;
   logic [BIT_WIDTH-1:0] p2_y_w;
   logic [BIT_WIDTH:0]   p1_bot;
   logic [BIT_WIDTH:0]   p2_bot;
   logic                 p1_cover;
   logic                 p2_cover;
   dir_t                 p1_dir;
   dir_t                 p2_dir;
   logic                 ball_left_d;
   logic                 ball_up_d;
   logic [BIT_WIDTH-1:0] ball_x_d;
   logic [BIT_WIDTH-1:0] ball_y_d;

   // A game step happens only on an unpaused tick.
   assign adv       = tick && !pause;
   assign paddle_en = adv && ((state_q == ST_SERVE) || (state_q == ST_PLAY));

   // Paddle vertical coverage, computed one bit wider so the bottom row cannot wrap.
   assign p1_bot   = {1'b0, p1_y_w} + PAD_SPAN;
   assign p2_bot   = {1'b0, p2_y_w} + PAD_SPAN;
   assign p1_cover = (p1_y_w <= ball_y_q) && ({1'b0, ball_y_q} <= p1_bot);
   assign p2_cover = (p2_y_w <= ball_y_q) && ({1'b0, ball_y_q} <= p2_bot);

   assign p1_dir = dir_t'(p1_dy);
`ifdef PONG_AI_PLAYER2_EN
   logic unused_p2_dy;
   assign unused_p2_dy = ^p2_dy;
   // Paddle 2 chases the ball row whenever the ball leaves its span.
   always_comb begin
      p2_dir      = '0;
      p2_dir.up   = (ball_y_q < p2_y_w);
      p2_dir.down = ({1'b0, ball_y_q} > p2_bot);
   end
`else
   assign p2_dir = dir_t'(p2_dy);
`endif

   pong_paddle #(
      .BIT_WIDTH (BIT_WIDTH),
      .MAX_POS   (PAD_MAX),
      .RESET_POS (PAD_RST)
   ) u_paddle1 (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (paddle_en),
      .dir_i  (p1_dir),
      .pos_o  (p1_y_w)
   );

   pong_paddle #(
      .BIT_WIDTH (BIT_WIDTH),
      .MAX_POS   (PAD_MAX),
      .RESET_POS (PAD_RST)
   ) u_paddle2 (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (paddle_en),
      .dir_i  (p2_dir),
      .pos_o  (p2_y_w)
   );

   // Bounce decisions are taken on the current position, then the ball steps.
   always_comb begin
      ball_up_d   = ball_up_q;
      ball_left_d = ball_left_q;
      if ((ball_up_q && (ball_y_q == '0)) || (!ball_up_q && (ball_y_q == MAX_Y_C))) begin
         ball_up_d = !ball_up_q;
      end
      if (ball_left_q && (ball_x_q == P1_HIT_X) && p1_cover) begin
         ball_left_d = 1'b0;
      end else if (!ball_left_q && (ball_x_q == P2_HIT_X) && p2_cover) begin
         ball_left_d = 1'b1;
      end
      ball_x_d = ball_left_d ? (ball_x_q - 1'b1) : (ball_x_q + 1'b1);
      ball_y_d = ball_up_d   ? (ball_y_q - 1'b1) : (ball_y_q + 1'b1);
   end

   // Game FSM with all game registers; point is a one-cycle registered pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         ball_x_q      <= CENTER_X;
         ball_y_q      <= CENTER_Y;
         ball_left_q   <= 1'b0;
         ball_up_q     <= 1'b0;
         serve_right_q <= 1'b1;
         serve_cnt_q   <= '0;
         score1_q      <= '0;
         score2_q      <= '0;
         win_q         <= WIN_NONE;
         point_q       <= 1'b0;
      end else begin
         point_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_SERVE;
                  serve_cnt_q <= '0;
                  ball_x_q    <= CENTER_X;
                  ball_y_q    <= CENTER_Y;
                  ball_left_q <= !serve_right_q;
                  ball_up_q   <= 1'b0;
               end
            end
            ST_SERVE: begin
               if (adv) begin
                  if (serve_cnt_q == SERVE_END) begin
                     state_q     <= ST_PLAY;
                     serve_cnt_q <= '0;
                  end else begin
                     serve_cnt_q <= serve_cnt_q + 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (adv) begin
                  ball_x_q    <= ball_x_d;
                  ball_y_q    <= ball_y_d;
                  ball_left_q <= ball_left_d;
                  ball_up_q   <= ball_up_d;
                  if (ball_x_d == '0) begin
                     // Player 1 missed: player 2 scores, next serve heads to player 1.
                     state_q       <= ST_POINT;
                     point_q       <= 1'b1;
                     score2_q      <= score2_q + 1'b1;
                     serve_right_q <= 1'b0;
                  end else if (ball_x_d == MAX_X_C) begin
                     state_q       <= ST_POINT;
                     point_q       <= 1'b1;
                     score1_q      <= score1_q + 1'b1;
                     serve_right_q <= 1'b1;
                  end
               end
            end
            ST_POINT: begin
               if (adv) begin
                  if (score1_q == SCORE_LIM) begin
                     state_q <= ST_GAMEOVER;
                     win_q   <= WIN_P1;
                  end else if (score2_q == SCORE_LIM) begin
                     state_q <= ST_GAMEOVER;
                     win_q   <= WIN_P2;
                  end else begin
                     state_q     <= ST_SERVE;
                     serve_cnt_q <= '0;
                     ball_x_q    <= CENTER_X;
                     ball_y_q    <= CENTER_Y;
                     ball_left_q <= !serve_right_q;
                     ball_up_q   <= 1'b0;
                  end
               end
            end
            ST_GAMEOVER: begin
               if (start) begin
                  state_q     <= ST_SERVE;
                  score1_q    <= '0;
                  score2_q    <= '0;
                  win_q       <= WIN_NONE;
                  serve_cnt_q <= '0;
                  ball_x_q    <= CENTER_X;
                  ball_y_q    <= CENTER_Y;
                  ball_left_q <= !serve_right_q;
                  ball_up_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ball_x = ball_x_q;
   assign ball_y = ball_y_q;
   assign p1_y   = p1_y_w;
   assign p2_y   = p2_y_w;
   assign score1 = score1_q;
   assign score2 = score2_q;
   assign win    = win_q;
   assign state  = state_q;
   assign point  = point_q;

endmodule

// File: tb/tb_pong_core.sv
// Directed bench for pong_core with hand-computed ball/paddle/score trajectories.
module tb_pong_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [1:0] p1_dy = 2'b00;
   logic [1:0] p2_dy = 2'b00;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] p1_y;
   logic [9:0] p2_y;
   logic [1:0] score1;
   logic [1:0] score2;
   logic [1:0] win;
   logic [2:0] state;
   logic       point;

   int n_assert = 0;
   int n_fail   = 0;

   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

   pong_core dut (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .start  (start),
      .pause  (pause),
      .p1_dy  (p1_dy),
      .p2_dy  (p2_dy),
      .ball_x (ball_x),
      .ball_y (ball_y),
      .p1_y   (p1_y),
      .p2_y   (p2_y),
      .score1 (score1),
      .score2 (score2),
      .win    (win),
      .state  (state),
      .point  (point)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ball(input string tag, input int ex, input int ey);
      chk({tag, ".x"}, 32'(ball_x), 32'(ex));
      chk({tag, ".y"}, 32'(ball_y), 32'(ey));
   endtask

   task automatic do_tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   initial begin
      // Reset values while reset is held
      #12;
      chk("rst.state", 32'(state), S_IDLE);
      chk_ball("rst.ball", 15, 11);
      chk("rst.p1_y", 32'(p1_y), 10);
      chk("rst.p2_y", 32'(p2_y), 10);
      chk("rst.score1", 32'(score1), 0);
      chk("rst.score2", 32'(score2), 0);
      chk("rst.win", 32'(win), 0);
      chk("rst.point", 32'(point), 0);
      @(negedge clk); rst = 1'b1;

      // Serve: four ticks then play, ball starts right/down
      pulse_start();
      chk("start.state", 32'(state), S_SERVE);
      do_tick(3);
      chk("serve3.state", 32'(state), S_SERVE);
      chk_ball("serve3.ball", 15, 11);
      do_tick(1);
      chk("serve4.state", 32'(state), S_PLAY);
      chk_ball("serve4.ball", 15, 11);
      do_tick(1);
      chk_ball("play1.ball", 16, 12);

      // Pause freezes ball and paddles
      pause = 1'b1; p1_dy = 2'b01;
      do_tick(10);
      chk_ball("pause.ball", 16, 12);
      chk("pause.state", 32'(state), S_PLAY);
      chk("pause.p1_y", 32'(p1_y), 10);
      chk("pause.p2_y", 32'(p2_y), 10);
      pause = 1'b0;

      // Both direction bits set: no movement
      p1_dy = 2'b11; p2_dy = 2'b10;
      do_tick(1);
      chk("dy11.p1_y", 32'(p1_y), 10);
      chk("down.p2_y", 32'(p2_y), 11);
      chk_ball("play2.ball", 17, 13);

      // p1 climbs to the top, p2 descends to the bottom
      p1_dy = 2'b01;
      do_tick(10);
      chk("up10.p1_y", 32'(p1_y), 0);
      chk("down.p2_y21", 32'(p2_y), 21);
      chk_ball("play12.ball", 27, 23);
      // Corner: wall and p2 hit together; both paddles clamped
      do_tick(1);
      chk("clamp.p1_y", 32'(p1_y), 0);
      chk("clamp.p2_y", 32'(p2_y), 21);
      chk_ball("corner2.ball", 26, 22);

      // Travel up-left to (4,0), then wall + p1 hit
      p1_dy = 2'b00; p2_dy = 2'b00;
      do_tick(22);
      chk_ball("play35.ball", 4, 0);
      do_tick(1);
      chk_ball("corner1.ball", 5, 1);

      // Lift p2 out of the way so player 1 scores
      p2_dy = 2'b01;
      do_tick(11);
      chk("lift.p2_y", 32'(p2_y), 10);
      chk_ball("play47.ball", 16, 12);
      p2_dy = 2'b00;
      do_tick(11);
      chk_ball("play58.ball", 27, 23);
      do_tick(1);
      chk_ball("wall.ball", 28, 22);
      do_tick(3);
      chk_ball("score.ball", 31, 19);
      chk("p1pt.state", 32'(state), S_POINT);
      chk("p1pt.point", 32'(point), 1);
      chk("p1pt.score1", 32'(score1), 1);
      chk("p1pt.score2", 32'(score2), 0);
      @(negedge clk);
      chk("p1pt.point_off", 32'(point), 0);
      chk("p1pt.hold", 32'(state), S_POINT);
      do_tick(1);
      chk("p1pt.serve", 32'(state), S_SERVE);
      chk_ball("reserve.ball", 15, 11);

      // Two more straight rallies: p2 at 10 misses at (27,23)
      do_tick(4 + 16);
      chk("p1pt2.score1", 32'(score1), 2);
      chk("p1pt2.state", 32'(state), S_POINT);
      do_tick(1 + 4 + 16);
      chk("p1pt3.score1", 32'(score1), 3);
      do_tick(1);
      chk("over.state", 32'(state), S_OVER);
      chk("over.win", 32'(win), 1);
      do_tick(1);
      chk("over.hold", 32'(state), S_OVER);

      // Restart clears scores and win
      pulse_start();
      chk("restart.state", 32'(state), S_SERVE);
      chk("restart.score1", 32'(score1), 0);
      chk("restart.score2", 32'(score2), 0);
      chk("restart.win", 32'(win), 0);

      // Rally where player 1 misses at (4,0) and player 2 scores
      p1_dy = 2'b10; p2_dy = 2'b10;
      do_tick(4);
      chk("r3.state", 32'(state), S_PLAY);
      chk("r3.p1_serve", 32'(p1_y), 4);
      do_tick(6);
      chk("r3.p1_y", 32'(p1_y), 10);
      p1_dy = 2'b00;
      do_tick(6);
      chk("r3.p2_y", 32'(p2_y), 21);
      chk_ball("r3.play12", 27, 23);
      do_tick(1);
      p2_dy = 2'b00;
      chk_ball("r3.corner", 26, 22);
      do_tick(22);
      chk_ball("r3.play35", 4, 0);
      do_tick(1);
      chk_ball("r3.miss", 3, 1);
      do_tick(3);
      chk_ball("r3.goal", 0, 4);
      chk("p2pt.state", 32'(state), S_POINT);
      chk("p2pt.point", 32'(point), 1);
      chk("p2pt.score2", 32'(score2), 1);
      chk("p2pt.score1", 32'(score1), 0);

      // Next serve goes left
      do_tick(1 + 4);
      chk("r4.state", 32'(state), S_PLAY);
      do_tick(1);
      chk_ball("r4.left", 14, 12);
      do_tick(2);
      chk_ball("r4.play3", 12, 14);

      // Reset mid-rally aborts with nothing awarded
      @(negedge clk); rst = 1'b0;
      #2;
      chk("mrst.state", 32'(state), S_IDLE);
      chk("mrst.score2", 32'(score2), 0);
      chk("mrst.point", 32'(point), 0);
      chk_ball("mrst.ball", 15, 11);
      @(negedge clk); rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
